hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined MIPS core. It sits beside the decode-stage control unit and tracks the destination register of every instruction in flight in a DEPTH-entry shift scoreboard. Each cycle it produces forwarding selects for rs/rt and a decode stall; the stall is computed per-stage rather than from a fixed 2-bit pause code. It also handles branch flush, whole-pipe hold for multi-cycle execute units, and a saturating stall-cycle counter for performance measurement.

## Interface
- DEPTH, 3: post-decode stages tracked (1=EX … DEPTH=WB); ≥2.
- ALU_READY, 2: lowest stage index from which a non-load result is forwardable; 1 ≤ ALU_READY ≤ DEPTH.
- LOAD_READY, 3: lowest stage index from which load data is forwardable; ALU_READY ≤ LOAD_READY ≤ DEPTH.
- SEL_W, $clog2(DEPTH+1): forwarding select width.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  core clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dec_valid_i  in  1  decode holds a real instruction.
- dec_rs_i, dec_rt_i  in  5 each  source register numbers.
- dec_use_rs_i, dec_use_rt_i  in  1 each  instruction reads rs / rt.
- dec_we_i  in  1  instruction writes a register (RegWE).
- dec_dst_i  in  5  destination after WriteRegSrc mux (rd/rt/31).
- dec_load_i  in  1  instruction is lw.
- flush_i  in  1  branch/jump redirect; kill the decode instruction.
- ex_hold_i  in  1  multi-cycle EX unit busy; freeze whole pipe.
- stall_o  out  1  hold PC and IF/ID; ID/EX receives a bubble.
- fwd_rs_o, fwd_rt_o  out  SEL_W each  0=register file, k=forward from stage k.
- stall_cnt_o  out  CNT_W  cycles with stall_o=1, saturating.

## Operation
- Scoreboard entry k (1..DEPTH): valid, dst[4:0], load. Entry k describes the instruction currently in stage k.
- Match on source s: entry valid, dst==s, s!=0, and use_s=1. The youngest (lowest k) match wins. No match gives fwd=0.
- Match readiness: the match is ready when k ≥ (load ? LOAD_READY : ALU_READY).
- fwd_s_o = k of the youngest match when dec_valid_i=1; otherwise 0. The value is driven even when the match is not ready; downstream ignores it under stall.
- hazard = dec_valid_i & (youngest rs match not ready | youngest rt match not ready).
- stall_o = ex_hold_i | (hazard & ~flush_i).
- Register 0 never matches. Writes to $0 enter the scoreboard with valid=0.
- Edge update when ex_hold_i=1: no shift, scoreboard unchanged; flush_i is ignored and the source must keep it asserted.
- Edge update when ex_hold_i=0:
  - entry k+1 ← entry k for k=1..DEPTH-1;
  - entry DEPTH retires, and the register file already holds its value;
  - entry 1 ← {dec_valid_i & dec_we_i & ~hazard & ~flush_i, dec_dst_i, dec_load_i}, otherwise a bubble (valid=0).
- stall_cnt_o increments on each edge where stall_o=1 and holds at all-ones.
- Reset (rst_n=0, async): all entries valid=0 and stall_cnt_o=0. Outputs then read stall_o=ex_hold_i and fwd=0 (the combinational outputs are forced 0 while in reset).

## Timing
- stall_o and fwd_* are combinational from the registered scoreboard plus the dec_* inputs. There is no added latency; they are valid in the same cycle as decode.
- Scoreboard and counter change only on the rising edge of clk, or asynchronously on rst_n fall.
- Load-use with defaults: a dependent instruction immediately after lw stalls 2 cycles, then forwards from stage 3. An ALU dependence stalls 1 cycle, then forwards from stage 2.
- The register file is write-first. Entries that have left stage DEPTH need no forwarding.
- flush_i and hazard in the same cycle: no stall, and the flushed instruction is not recorded.
- Reset deasserted mid-hazard: the empty scoreboard guarantees no stall on the first cycle.

## Test plan
- Reset: rst_n=0 with ex_hold_i=0 → stall_o=0, fwd_rs_o=fwd_rt_o=0, stall_cnt_o=0; after release, no stalls for any decode stream against an empty board.
- ALU dependence: `addu $3,$1,$2` then `subu $4,$3,$5` → 1 stall cycle with fwd_rs_o=1 (not ready); next cycle stall_o=0, fwd_rs_o=2, stall_cnt_o=1.
- Load-use: `lw $8,0($9)` then `or $10,$8,$8` → stall_o=1 for 2 cycles, then fwd_rs_o=fwd_rt_o=3 with stall_o=0; stall_cnt_o=2.
- Youngest wins: `addu $5,…`, `ori $5,…`, `addu $7,$5,$0` → once the ori is in stage 2 and the addu in stage 3, fwd_rs_o=2; with dec_rs_i=0 the select is always 0.
- Flush and hold: hazard with flush_i=1 → stall_o=0 and the next entry 1 is invalid. With ex_hold_i=1 for 3 cycles, stall_o=1 and the scoreboard is frozen; selects are unchanged after release.
- Saturation: with CNT_W=4, hold ex_hold_i=1 for 20 cycles → stall_cnt_o=15; rst_n pulse mid-count → 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the pipelined MIPS core: tracks in-flight
// destination registers in a DEPTH-entry shift scoreboard and derives stall/forward selects.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 2,
    parameter int LOAD_READY = 3,
    parameter int SEL_W      = $clog2(DEPTH + 1),
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid_i,
    input  logic [4:0]       dec_rs_i,
    input  logic [4:0]       dec_rt_i,
    input  logic             dec_use_rs_i,
    input  logic             dec_use_rt_i,
    input  logic             dec_we_i,
    input  logic [4:0]       dec_dst_i,
    input  logic             dec_load_i,
    input  logic             flush_i,
    input  logic             ex_hold_i,
    output logic             stall_o,
    output logic [SEL_W-1:0] fwd_rs_o,
    output logic [SEL_W-1:0] fwd_rt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       load;
    } entry_t;

    // Entry k describes the instruction currently in post-decode stage k.
    entry_t sb [1:DEPTH];

    logic [SEL_W-1:0] rs_k, rt_k;
    logic             rs_not_ready, rt_not_ready;
    logic             hazard;

    // NOTE: every variable gets a default before the search loop; without it
    // the "no match" path would infer a latch.
    always_comb begin
        rs_k         = '0;
        rt_k         = '0;
        rs_not_ready = 1'b0;
        rt_not_ready = 1'b0;
        // Walk oldest to youngest so the youngest (lowest k) match overwrites.
        for (int k = DEPTH; k >= 1; k--) begin
            if (sb[k].valid && dec_use_rs_i && dec_rs_i != 5'd0 && sb[k].dst == dec_rs_i) begin
                rs_k         = SEL_W'(k);
                rs_not_ready = k < (sb[k].load ? LOAD_READY : ALU_READY);
            end
            if (sb[k].valid && dec_use_rt_i && dec_rt_i != 5'd0 && sb[k].dst == dec_rt_i) begin
                rt_k         = SEL_W'(k);
                rt_not_ready = k < (sb[k].load ? LOAD_READY : ALU_READY);
            end
        end
    end

    assign hazard   = rst_n & dec_valid_i & (rs_not_ready | rt_not_ready);
    assign stall_o  = ex_hold_i | (hazard & ~flush_i);
    assign fwd_rs_o = (rst_n && dec_valid_i) ? rs_k : '0;
    assign fwd_rt_o = (rst_n && dec_valid_i) ? rt_k : '0;

    // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset
    // directly; stale valid bits after reset would cause phantom stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else if (!ex_hold_i) begin
            // NOTE: non-blocking assignments make the shift read old values of every entry.
            for (int k = DEPTH; k >= 2; k--) begin
                sb[k] <= sb[k-1];
            end
            sb[1] <= '{valid: dec_valid_i & dec_we_i & ~hazard & ~flush_i & (dec_dst_i != 5'd0),
                       dst:   dec_dst_i,
                       load:  dec_load_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (stall_o && stall_cnt_o != {CNT_W{1'b1}}) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule
